// File: rtl/uart_tx_if.sv
// Host-side handshake and line outputs of the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;
    logic                  tx;
    logic                  tx_busy;
    logic                  tx_done;

    modport master (output tx_valid, tx_data, input tx_ready, tx, tx_busy, tx_done);
    modport slave  (input tx_valid, tx_data, output tx_ready, tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, 1-2 stop bits.
// The line output is registered from the next-state decode so it changes exactly on state edges.
module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input logic      clk,
    input logic      rst,
    uart_tx_if.slave tx_if
);
    localparam int CLK_DIVIDE = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W      = (CLK_DIVIDE > 1) ? $clog2(CLK_DIVIDE) : 1;
    localparam int IDX_W      = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIVIDE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic             PARITY_ON = (PARITY_EN != 0);
    localparam logic             ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                r_state,    w_state_nxt;
    logic [CNT_W-1:0]      r_baud_cnt, w_baud_cnt_nxt;
    logic [IDX_W-1:0]      r_bit_idx,  w_bit_idx_nxt;
    logic [DATA_WIDTH-1:0] r_shift,    w_shift_nxt;
    logic                  r_parity,   w_parity_nxt;
    logic                  r_tx,       w_tx_nxt;
    logic                  w_bit_end;

    assign w_bit_end = (r_baud_cnt == CNT_LAST);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + CNT_ONE;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_tx_nxt       = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baud_cnt_nxt = '0;
                w_bit_idx_nxt  = '0;
                if (tx_if.tx_valid) begin
                    w_state_nxt  = S_START;
                    w_shift_nxt  = tx_if.tx_data;
                    w_parity_nxt = (^tx_if.tx_data) ^ ODD_BIT;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_idx == DATA_LAST) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = PARITY_ON ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // bit index doubles as the stop-bit counter
                if (w_bit_end) begin
                    if (r_bit_idx == STOP_LAST) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = S_DONE;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_ONE;
                    end
                end
            end
            S_DONE: begin
                w_baud_cnt_nxt = '0;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_baud_cnt_nxt = '0;
                w_bit_idx_nxt  = '0;
                w_state_nxt    = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_parity_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    assign tx_if.tx       = r_tx;
    assign tx_if.tx_ready = (r_state == S_IDLE);
    assign tx_if.tx_done  = (r_state == S_DONE);
    assign tx_if.tx_busy  = (r_state inside {S_START, S_DATA, S_PARITY, S_STOP, S_DONE});
endmodule
